// File: rtl/oversample_phase_ctrl.sv
// Phase-select controller for a 4x oversampled receive path: edge histogram, phase pick, bit recovery.
// Optional statistics ports are built when OSCTRL_STATS_EN is defined.
module oversample_phase_ctrl #(
   parameter int ACC_CYCLES = 64,
   parameter int CNT_W      = 8,
   parameter int MIN_EDGES  = 8,
   parameter int LOCK_WINS  = 4,
   parameter int LOSS_WINS  = 4
) (
   input  logic       clk,
   input  logic       aresetn,
   input  logic       enable,
   input  logic       sample_valid,
   input  logic [7:0] sample_window,
   output logic [2:0] data_out,
   output logic [1:0] data_cnt,
   output logic       data_valid,
   output logic [1:0] phase_sel,
   output logic       locked
`ifdef OSCTRL_STATS_EN
   ,
   output logic [15:0] phase_adj_cnt,
   output logic [7:0]  lock_loss_cnt
`endif
);

   localparam int WC_W   = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
   localparam int GOOD_W = $clog2(LOCK_WINS + 1);
   localparam int BAD_W  = $clog2(LOSS_WINS + 1);
   localparam int TOT_W  = CNT_W + 2;

   localparam logic [WC_W-1:0]   WC_LAST   = WC_W'(ACC_CYCLES - 1);
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_WINS - 1);
   localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_WINS - 1);
   localparam logic [TOT_W-1:0]  MIN_TOT   = TOT_W'(MIN_EDGES);

   typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;
   typedef enum logic [1:0] {WRAP_NONE, WRAP_INC, WRAP_DEC} wrap_t;

   state_t state, state_next;
   wrap_t  wrap, wrap_next;

   logic [1:0]        phase_next;
   logic [GOOD_W-1:0] good_cnt, good_next;
   logic [BAD_W-1:0]  bad_cnt, bad_next;

   logic [7:0]       s_t;
   logic [7:0]       edge_vec;
   logic [1:0]       inc [4];
   logic [CNT_W-1:0] hist [4];
   logic [CNT_W-1:0] hist_add [4];
   logic [CNT_W-1:0] snap [4];
   logic [CNT_W-1:0] best_val;
   logic [1:0]       best_idx;
   logic [1:0]       target;
   logic [1:0]       diff;
   logic [TOT_W-1:0] total;
   logic [WC_W-1:0]  win_cnt;
   logic             prev;
   logic             dec_pending;
   logic             take;
   logic             close;
   logic             enough;

   assign take  = enable & sample_valid;
   assign close = take && (win_cnt == WC_LAST);

   // Reorder the window into time order and find edges, folding t and t+4 into one bin.
   always_comb begin
      for (int t = 0; t < 8; t++) begin
         s_t[t] = sample_window[7-t];
      end
      edge_vec[0] = s_t[0] ^ prev;
      for (int t = 1; t < 8; t++) begin
         edge_vec[t] = s_t[t] ^ s_t[t-1];
      end
      for (int b = 0; b < 4; b++) begin
         inc[b] = {1'b0, edge_vec[b]} + {1'b0, edge_vec[b+4]};
      end
   end

   always_comb begin
      logic [CNT_W:0] sum;
      sum = '0;
      for (int b = 0; b < 4; b++) begin
         sum         = {1'b0, hist[b]} + (CNT_W+1)'(inc[b]);
         hist_add[b] = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      end
   end

   // Decision from the closed window: strict greater-than keeps the lowest index on ties.
   always_comb begin
      best_idx = 2'd0;
      best_val = snap[0];
      total    = '0;
      for (int b = 0; b < 4; b++) begin
         total = total + TOT_W'(snap[b]);
      end
      for (int b = 1; b < 4; b++) begin
         if (snap[b] > best_val) begin
            best_val = snap[b];
            best_idx = 2'(b);
         end
      end
      target = best_idx + 2'd2;
      diff   = target - phase_sel;
      enough = (total >= MIN_TOT);
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         for (int b = 0; b < 4; b++) begin
            hist[b] <= '0;
            snap[b] <= '0;
         end
         win_cnt     <= '0;
         prev        <= 1'b0;
         dec_pending <= 1'b0;
      end else if (!enable) begin
         for (int b = 0; b < 4; b++) begin
            hist[b] <= '0;
         end
         win_cnt     <= '0;
         prev        <= 1'b0;
         dec_pending <= 1'b0;
      end else begin
         dec_pending <= close;
         if (take) begin
            prev <= s_t[7];
            if (close) begin
               for (int b = 0; b < 4; b++) begin
                  snap[b] <= hist_add[b];
                  hist[b] <= '0;
               end
               win_cnt <= '0;
            end else begin
               for (int b = 0; b < 4; b++) begin
                  hist[b] <= hist_add[b];
               end
               win_cnt <= win_cnt + WC_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= IDLE;
         wrap      <= WRAP_NONE;
         phase_sel <= 2'd0;
         good_cnt  <= '0;
         bad_cnt   <= '0;
      end else begin
         state     <= state_next;
         wrap      <= wrap_next;
         phase_sel <= phase_next;
         good_cnt  <= good_next;
         bad_cnt   <= bad_next;
      end
   end

   // A wrap flag set by a phase step survives until the next valid cycle consumes it.
   always_comb begin
      state_next = state;
      phase_next = phase_sel;
      good_next  = good_cnt;
      bad_next   = bad_cnt;
      wrap_next  = take ? WRAP_NONE : wrap;
      if (!enable) begin
         state_next = IDLE;
         good_next  = '0;
         bad_next   = '0;
         wrap_next  = WRAP_NONE;
      end else begin
         if (state == IDLE) begin
            state_next = ACQ;
         end
         if (dec_pending) begin
            case (state)
               ACQ: begin
                  if (!enough) begin
                     good_next = '0;
                  end else if (target == phase_sel) begin
                     if (good_cnt == GOOD_LAST) begin
                        state_next = TRACK;
                        good_next  = '0;
                        bad_next   = '0;
                     end else begin
                        good_next = good_cnt + GOOD_W'(1);
                     end
                  end else begin
                     good_next  = '0;
                     phase_next = target;
                  end
               end
               TRACK: begin
                  if (!enough) begin
                     if (bad_cnt == BAD_LAST) begin
                        state_next = ACQ;
                        bad_next   = '0;
                        good_next  = '0;
                     end else begin
                        bad_next = bad_cnt + BAD_W'(1);
                     end
                  end else begin
                     bad_next = '0;
                     if (diff == 2'd3) begin
                        phase_next = phase_sel - 2'd1;
                        if (phase_sel == 2'd0) begin
                           wrap_next = WRAP_DEC;
                        end
                     end else if (diff != 2'd0) begin
                        phase_next = phase_sel + 2'd1;
                        if (phase_sel == 2'd3) begin
                           wrap_next = WRAP_INC;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Recovered bits; a +1 wrap drops the duplicate sample, a -1 wrap adds the skipped one.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         data_out   <= 3'd0;
         data_cnt   <= 2'd0;
         data_valid <= 1'b0;
      end else if (!take) begin
         data_valid <= 1'b0;
      end else begin
         data_valid <= 1'b1;
         case (wrap)
            WRAP_INC: begin
               data_cnt <= 2'd1;
               data_out <= {2'b00, s_t[4]};
            end
            WRAP_DEC: begin
               data_cnt <= 2'd3;
               data_out <= {s_t[0], s_t[3], s_t[7]};
            end
            default: begin
               data_cnt <= 2'd2;
               data_out <= {1'b0, s_t[{1'b0, phase_sel}], s_t[{1'b1, phase_sel}]};
            end
         endcase
      end
   end

   assign locked = (state == TRACK);

`ifdef OSCTRL_STATS_EN
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         phase_adj_cnt <= '0;
         lock_loss_cnt <= '0;
      end else begin
         if ((phase_next != phase_sel) && (phase_adj_cnt != 16'hFFFF)) begin
            phase_adj_cnt <= phase_adj_cnt + 16'd1;
         end
         if ((state == TRACK) && (state_next == ACQ) && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_oversample_phase_ctrl.sv
// Self-checking bench for oversample_phase_ctrl: window-level reference model plus directed checks.
module tb_oversample_phase_ctrl;

   localparam int ACC   = 16;
   localparam int CW    = 5;
   localparam int MINE  = 8;
   localparam int LOCKW = 4;
   localparam int LOSSW = 4;
   localparam int MAXB  = (1 << CW) - 1;

   logic       clk = 1'b0;
   logic       aresetn = 1'b1;
   logic       enable = 1'b0;
   logic       sample_valid = 1'b0;
   logic [7:0] sample_window = 8'h00;
   logic [2:0] data_out;
   logic [1:0] data_cnt;
   logic       data_valid;
   logic [1:0] phase_sel;
   logic       locked;
`ifdef OSCTRL_STATS_EN
   logic [15:0] phase_adj_cnt;
   logic [7:0]  lock_loss_cnt;
`endif

   always #5 clk = ~clk;

   oversample_phase_ctrl #(
      .ACC_CYCLES(ACC), .CNT_W(CW), .MIN_EDGES(MINE), .LOCK_WINS(LOCKW), .LOSS_WINS(LOSSW)
   ) dut (
      .clk(clk), .aresetn(aresetn), .enable(enable), .sample_valid(sample_valid),
      .sample_window(sample_window), .data_out(data_out), .data_cnt(data_cnt),
      .data_valid(data_valid), .phase_sel(phase_sel), .locked(locked)
`ifdef OSCTRL_STATS_EN
      , .phase_adj_cnt(phase_adj_cnt), .lock_loss_cnt(lock_loss_cnt)
`endif
   );

   int checks = 0;
   int failures = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference model: mode 0=idle 1=acquire 2=tracking; wrap +1/-1 pending compensation.
   int m_hist [4];
   int m_snap [4];
   int m_cnt, m_mode, m_good, m_bad, m_wrap, m_phase;
   bit m_prev, m_dec, m_close, m_dec_now;
   bit ms [8];
   int exp_valid = 0, exp_cnt = 0, exp_data = 0, exp_phase = 0, exp_locked = 0;

   task automatic modelDecide();
      int tot, best, tgt, d;
      tot = 0;
      best = 0;
      for (int b = 0; b < 4; b++) begin
         tot += m_snap[b];
         if (m_snap[b] > m_snap[best]) best = b;
      end
      tgt = (best + 2) % 4;
      if (tot < MINE) begin
         if (m_mode == 2) begin
            m_bad++;
            if (m_bad == LOSSW) begin
               m_mode = 1;
               m_bad = 0;
               m_good = 0;
            end
         end else begin
            m_good = 0;
         end
      end else if (m_mode == 1) begin
         if (tgt == m_phase) begin
            m_good++;
            if (m_good == LOCKW) begin
               m_mode = 2;
               m_good = 0;
               m_bad = 0;
            end
         end else begin
            m_good = 0;
            m_phase = tgt;
         end
      end else begin
         m_bad = 0;
         d = (tgt - m_phase + 4) % 4;
         if (d == 3) begin
            if (m_phase == 0) m_wrap = -1;
            m_phase = (m_phase + 3) % 4;
         end else if (d != 0) begin
            if (m_phase == 3) m_wrap = 1;
            m_phase = (m_phase + 1) % 4;
         end
      end
   endtask

   task automatic modelClearWindow();
      for (int b = 0; b < 4; b++) m_hist[b] = 0;
      m_cnt = 0;
      m_prev = 0;
      m_dec = 0;
   endtask

   always @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         modelClearWindow();
         for (int b = 0; b < 4; b++) m_snap[b] = 0;
         m_mode = 0; m_good = 0; m_bad = 0; m_wrap = 0; m_phase = 0;
         exp_valid = 0;
      end else if (!enable) begin
         modelClearWindow();
         m_mode = 0; m_good = 0; m_bad = 0; m_wrap = 0;
         exp_valid = 0;
      end else begin
         m_dec_now = m_dec;
         m_close = 0;
         if (m_mode == 0) m_mode = 1;
         if (sample_valid) begin
            for (int t = 0; t < 8; t++) ms[t] = sample_window[7-t];
            if (m_wrap == 1) begin
               exp_cnt = 1;
               exp_data = int'(ms[4]);
            end else if (m_wrap == -1) begin
               exp_cnt = 3;
               exp_data = 4 * int'(ms[0]) + 2 * int'(ms[3]) + int'(ms[7]);
            end else begin
               exp_cnt = 2;
               exp_data = 2 * int'(ms[m_phase]) + int'(ms[m_phase + 4]);
            end
            m_wrap = 0;
            exp_valid = 1;
         end else begin
            exp_valid = 0;
         end
         if (m_dec_now) modelDecide();
         if (sample_valid) begin
            for (int t = 0; t < 8; t++) begin
               if (ms[t] != ((t == 0) ? m_prev : ms[t-1])) begin
                  if (m_hist[t % 4] < MAXB) m_hist[t % 4]++;
               end
            end
            m_prev = ms[7];
            m_cnt++;
            if (m_cnt == ACC) begin
               for (int b = 0; b < 4; b++) begin
                  m_snap[b] = m_hist[b];
                  m_hist[b] = 0;
               end
               m_cnt = 0;
               m_close = 1;
            end
         end
         m_dec = m_close;
      end
      exp_phase = m_phase;
      exp_locked = (m_mode == 2) ? 1 : 0;
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      checkOutput("cyc_data_valid", int'(data_valid), exp_valid);
      checkOutput("cyc_phase_sel", int'(phase_sel), exp_phase);
      checkOutput("cyc_locked", int'(locked), exp_locked);
      if (exp_valid != 0) begin
         checkOutput("cyc_data_cnt", int'(data_cnt), exp_cnt);
         checkOutput("cyc_data_out", int'(data_out) & ((1 << exp_cnt) - 1), exp_data);
      end
   end

   task automatic applyStimulus(input logic en, input logic v, input logic [7:0] w);
      enable = en;
      sample_valid = v;
      sample_window = w;
      @(posedge clk);
      #1;
   endtask

   task automatic runCycles(input int n, input logic [7:0] w);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, w);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #1 aresetn = 1'b0;
      #1;
      checkOutput("rst_data_valid", int'(data_valid), 0);
      checkOutput("rst_data_cnt", int'(data_cnt), 0);
      checkOutput("rst_data_out", int'(data_out), 0);
      checkOutput("rst_phase_sel", int'(phase_sel), 0);
      checkOutput("rst_locked", int'(locked), 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      aresetn = 1'b1;

      $display("[TB] idle line");
      runCycles(10 * ACC, 8'h00);
      checkOutput("idle_data_valid", int'(data_valid), 1);
      checkOutput("idle_data_out", int'(data_out), 0);
      checkOutput("idle_data_cnt", int'(data_cnt), 2);
      checkOutput("idle_locked", int'(locked), 0);
      checkOutput("idle_phase", int'(phase_sel), 0);

      $display("[TB] alternating pattern, edges in bin 1");
      runCycles(ACC, 8'h78);
      checkOutput("alt_phase_before_dec", int'(phase_sel), 0);
      runCycles(1, 8'h78);
      checkOutput("alt_phase_w1", int'(phase_sel), 3);
      runCycles(ACC - 1, 8'h78);
      checkOutput("alt_data_p3", int'(data_out), 3'b010);
      runCycles(3 * ACC, 8'h78);
      checkOutput("alt_unlocked_w5", int'(locked), 0);
      runCycles(1, 8'h78);
      checkOutput("alt_locked_w6", int'(locked), 1);
      runCycles(ACC - 1, 8'h78);

      $display("[TB] drift into bin 2 from phase 3");
      runCycles(ACC, 8'h3C);
      runCycles(1, 8'h3C);
      checkOutput("wrapinc_phase", int'(phase_sel), 0);
      runCycles(1, 8'h3C);
      checkOutput("wrapinc_cnt", int'(data_cnt), 1);
      checkOutput("wrapinc_bit", int'(data_out[0]), 1);
      runCycles(ACC - 2, 8'h3C);
      runCycles(ACC, 8'h3C);

      $display("[TB] drift into bin 1 from phase 0");
      runCycles(ACC, 8'h78);
      runCycles(1, 8'h78);
      checkOutput("wrapdec_phase", int'(phase_sel), 3);
      runCycles(1, 8'h78);
      checkOutput("wrapdec_cnt", int'(data_cnt), 3);
      checkOutput("wrapdec_bits", int'(data_out), 3'b010);
      runCycles(ACC - 2, 8'h78);

      $display("[TB] distance-two target from phase 3");
      runCycles(ACC, 8'h1E);
      runCycles(1, 8'h1E);
      checkOutput("dist2_phase", int'(phase_sel), 0);
      runCycles(1, 8'h1E);
      checkOutput("dist2_cnt", int'(data_cnt), 1);
      runCycles(ACC - 2, 8'h1E);
      runCycles(1, 8'h1E);
      checkOutput("dist2_phase_next", int'(phase_sel), 1);
      runCycles(ACC - 1, 8'h1E);

      $display("[TB] constant input, loss of lock");
      checkOutput("loss_locked_before", int'(locked), 1);
      for (int i = 0; i < LOSSW * ACC; i++) begin
         if (i % 5 == 2) applyStimulus(1'b1, 1'b0, 8'hFF);
         applyStimulus(1'b1, 1'b1, 8'hFF);
      end
      checkOutput("loss_locked_pending", int'(locked), 1);
      runCycles(1, 8'hFF);
      checkOutput("loss_locked_after", int'(locked), 0);
      checkOutput("loss_phase_kept", int'(phase_sel), 1);
      runCycles(ACC - 1, 8'hFF);

      $display("[TB] reset mid-window");
      runCycles(7, 8'h78);
      aresetn = 1'b0;
      #1;
      checkOutput("midrst_data_valid", int'(data_valid), 0);
      checkOutput("midrst_phase", int'(phase_sel), 0);
      @(posedge clk); #1;
      aresetn = 1'b1;
      runCycles(ACC, 8'h78);
      checkOutput("midrst_no_early_dec", int'(phase_sel), 0);
      runCycles(1, 8'h78);
      checkOutput("midrst_first_dec", int'(phase_sel), 3);
      runCycles(ACC - 1, 8'h78);

      $display("[TB] enable drop mid-window");
      runCycles(7, 8'h3C);
      applyStimulus(1'b0, 1'b1, 8'h3C);
      checkOutput("endrop_data_valid", int'(data_valid), 0);
      checkOutput("endrop_phase_kept", int'(phase_sel), 3);
      runCycles(ACC, 8'h3C);
      checkOutput("endrop_no_early_dec", int'(phase_sel), 3);
      runCycles(1, 8'h3C);
      checkOutput("endrop_first_dec", int'(phase_sel), 0);
      runCycles(4, 8'h3C);
      applyStimulus(1'b0, 1'b0, 8'h00);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
